// File: rtl/tx_packetizer_if.sv
// tx_packetizer_if: control, payload and serial-output bundle of the packetizer.
//   clk_enable            bit-rate strobe
//   start, len            packet request and payload length (bytes)
//   data_in, data_valid,
//   data_ready            payload byte handshake
//   bit_out, bit_vld,
//   trn_flag              serial output bit, valid, training-prefix flag
//   busy, pkt_done,
//   underflow             status
// master = packet source / bit sink (testbench); slave = tx_packetizer.
interface tx_packetizer_if #(
  parameter int unsigned LEN_WIDTH = 8
) ();
  logic                 clk_enable;
  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic [7:0]           data_in;
  logic                 data_valid;
  logic                 data_ready;
  logic                 bit_out;
  logic                 bit_vld;
  logic                 trn_flag;
  logic                 busy;
  logic                 pkt_done;
  logic                 underflow;

  modport master (
    output clk_enable, start, len, data_in, data_valid,
    input  data_ready, bit_out, bit_vld, trn_flag, busy, pkt_done, underflow
  );

  modport slave (
    input  clk_enable, start, len, data_in, data_valid,
    output data_ready, bit_out, bit_vld, trn_flag, busy, pkt_done, underflow
  );
endinterface

// File: rtl/tx_packetizer.sv
// tx_packetizer: serialises one packet as TRN training field, LEN_WIDTH-bit length
// header (MSB first) and len payload bytes (MSB first), one bit per clk_enable strobe.
// Ports:
//   i_clk   sole clock, rising edge
//   i_rst   asynchronous reset, active low
//   io_bus  tx_packetizer_if.slave (strobe, start/len, byte handshake, bit output, status)
// A one-byte prefetch buffer is filled on any clk edge; bytes are moved into the
// shift register only on strobe edges at byte boundaries. A missing byte is sent
// as 0x00 and flagged in the sticky underflow bit.
module tx_packetizer #(
  parameter int unsigned TRN_LEN   = 256,
  parameter int unsigned TRN_POS   = 224,
  parameter int unsigned LEN_WIDTH = 8
) (
  input logic            i_clk,
  input logic            i_rst,
  tx_packetizer_if.slave io_bus
);

  localparam int unsigned MaxFld = (LEN_WIDTH > 8) ? LEN_WIDTH : 8;
  localparam int unsigned MaxCnt = (TRN_LEN > MaxFld) ? TRN_LEN : MaxFld;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] CntTrnLen = CntW'(TRN_LEN);
  localparam logic [CntW-1:0] CntTrnPos = CntW'(TRN_POS);
  localparam logic [CntW-1:0] CntHdrLen = CntW'(LEN_WIDTH);
  localparam logic [CntW-1:0] CntByte   = CntW'(8);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TRN  = 2'd1;
  localparam logic [1:0] ST_HDR  = 2'd2;
  localparam logic [1:0] ST_PAY  = 2'd3;

  logic [1:0]           r_state;
  logic                 r_start_pend;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_bytes_left;  // payload bytes still to be loaded for emission
  logic [LEN_WIDTH-1:0] r_fetch_left;  // payload bytes still to be taken from data_in
  logic [CntW-1:0]      r_cnt;         // bits already emitted in the current field
  logic [LEN_WIDTH-1:0] r_hdr_sh;
  logic [7:0]           r_shift;
  logic [7:0]           r_buf;
  logic                 r_buf_full;
  logic                 r_bit_out;
  logic                 r_bit_vld;
  logic                 r_trn_flag;
  logic                 r_pkt_done;
  logic                 r_underflow;

  logic       w_busy;
  logic       w_data_ready;
  logic       w_xfer;
  logic       w_start_acc;
  logic       w_trn_bit;
  logic       w_hdr_end;
  logic       w_pay_end;
  logic       w_load;
  logic       w_finish;
  logic [7:0] w_byte;

  assign w_busy       = r_start_pend | (r_state != ST_IDLE);
  assign w_data_ready = ~r_buf_full & (r_state != ST_IDLE) & (r_fetch_left != '0);
  assign w_xfer       = io_bus.data_valid & w_data_ready;
  // A start in the pkt_done cycle is dropped so back-to-back requests cannot slip in.
  assign w_start_acc  = io_bus.start & ~w_busy & ~r_pkt_done;

  // Phase flips at TRN_POS, giving the single repeated pair at TRN_POS-1/TRN_POS.
  assign w_trn_bit = r_cnt[0] ^ (r_cnt >= CntTrnPos);

  assign w_hdr_end = (r_state == ST_HDR) & (r_cnt == CntHdrLen);
  assign w_pay_end = (r_state == ST_PAY) & (r_cnt == CntByte);
  assign w_load    = io_bus.clk_enable &
                     ((w_hdr_end & (r_len != '0)) | (w_pay_end & (r_bytes_left != '0)));
  assign w_finish  = (w_hdr_end & (r_len == '0)) | (w_pay_end & (r_bytes_left == '0));

  // A byte arriving on the very edge it is needed bypasses the empty buffer.
  assign w_byte = r_buf_full ? r_buf : (w_xfer ? io_bus.data_in : 8'h00);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_start_pend <= 1'b0;
      r_len        <= '0;
      r_bytes_left <= '0;
      r_fetch_left <= '0;
      r_cnt        <= '0;
      r_hdr_sh     <= '0;
      r_shift      <= '0;
      r_buf        <= '0;
      r_buf_full   <= 1'b0;
      r_bit_out    <= 1'b0;
      r_bit_vld    <= 1'b0;
      r_trn_flag   <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;

      if (w_start_acc) begin
        r_start_pend <= 1'b1;
        r_len        <= io_bus.len;
        r_underflow  <= 1'b0;
      end

      // Prefetch buffer, independent of the bit strobe.
      if (w_load) begin
        if (r_buf_full) begin
          r_buf_full <= 1'b0;
        end else begin
          // Either bypassed or skipped: that byte slot is consumed either way.
          r_fetch_left <= r_fetch_left - LEN_WIDTH'(1);
          if (!w_xfer) begin
            r_underflow <= 1'b1;
          end
        end
      end else if (w_xfer) begin
        r_buf        <= io_bus.data_in;
        r_buf_full   <= 1'b1;
        r_fetch_left <= r_fetch_left - LEN_WIDTH'(1);
      end

      if (io_bus.clk_enable) begin
        if (w_finish) begin
          r_state      <= ST_IDLE;
          r_bit_out    <= 1'b0;
          r_bit_vld    <= 1'b0;
          r_trn_flag   <= 1'b0;
          r_pkt_done   <= 1'b1;
          r_cnt        <= '0;
          r_buf_full   <= 1'b0;
          r_fetch_left <= '0;
        end else begin
          unique case (r_state)
            ST_IDLE: begin
              if (r_start_pend) begin
                r_start_pend <= 1'b0;
                r_state      <= ST_TRN;
                r_bit_out    <= 1'b0;
                r_bit_vld    <= 1'b1;
                r_trn_flag   <= 1'b1;
                r_cnt        <= CntOne;
                r_bytes_left <= r_len;
                r_fetch_left <= r_len;
              end
            end
            ST_TRN: begin
              if (r_cnt < CntTrnLen) begin
                r_bit_out  <= w_trn_bit;
                r_trn_flag <= (r_cnt < CntTrnPos);
                r_cnt      <= r_cnt + CntOne;
              end else begin
                r_state    <= ST_HDR;
                r_bit_out  <= r_len[LEN_WIDTH-1];
                r_hdr_sh   <= {r_len[LEN_WIDTH-2:0], 1'b0};
                r_trn_flag <= 1'b0;
                r_cnt      <= CntOne;
              end
            end
            ST_HDR: begin
              if (r_cnt < CntHdrLen) begin
                r_bit_out <= r_hdr_sh[LEN_WIDTH-1];
                r_hdr_sh  <= {r_hdr_sh[LEN_WIDTH-2:0], 1'b0};
                r_cnt     <= r_cnt + CntOne;
              end else begin
                r_state      <= ST_PAY;
                r_bit_out    <= w_byte[7];
                r_shift      <= {w_byte[6:0], 1'b0};
                r_bytes_left <= r_bytes_left - LEN_WIDTH'(1);
                r_cnt        <= CntOne;
              end
            end
            ST_PAY: begin
              if (r_cnt < CntByte) begin
                r_bit_out <= r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_cnt     <= r_cnt + CntOne;
              end else begin
                r_bit_out    <= w_byte[7];
                r_shift      <= {w_byte[6:0], 1'b0};
                r_bytes_left <= r_bytes_left - LEN_WIDTH'(1);
                r_cnt        <= CntOne;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign io_bus.data_ready = w_data_ready;
  assign io_bus.bit_out    = r_bit_out;
  assign io_bus.bit_vld    = r_bit_vld;
  assign io_bus.trn_flag   = r_trn_flag;
  assign io_bus.busy       = w_busy;
  assign io_bus.pkt_done   = r_pkt_done;
  assign io_bus.underflow  = r_underflow;

endmodule

// File: tb/tb_tx_packetizer.sv
// Testbench for tx_packetizer with TRN_LEN=16, TRN_POS=12, LEN_WIDTH=8.
// Stimulus pushes expected bits into a queue; an independent monitor pops and
// compares on every strobe edge where bit_vld is high.
module tb_tx_packetizer;

  localparam int unsigned TrnLen = 16;
  localparam int unsigned TrnPos = 12;
  localparam int unsigned LenW   = 8;
  // Hand-derived training pattern, first emitted bit on the left.
  localparam logic [15:0] TrnPattern = 16'b0101_0101_0101_1010;

  typedef struct packed {
    logic b;
    logic f;
  } exp_t;

  logic clk;
  logic rst_n;

  tx_packetizer_if #(.LEN_WIDTH(LenW)) bus ();

  tx_packetizer #(
    .TRN_LEN  (TrnLen),
    .TRN_POS  (TrnPos),
    .LEN_WIDTH(LenW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [7:0] feed_q[$];
  int         n_checks;
  int         n_errors;
  int         done_cnt;
  int         bits_seen;
  int         off_strobe_xfers;
  int         en_period;
  bit         dr_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-rate strobe: high one clk out of every en_period.
  initial begin
    int c;
    c = 0;
    bus.clk_enable = 1'b0;
    forever begin
      @(negedge clk);
      bus.clk_enable = (c == 0);
      c = (c + 1 >= en_period) ? 0 : c + 1;
    end
  end

  // Payload source: offers the head of feed_q, pops it when accepted.
  initial begin
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    forever begin
      @(negedge clk);
      if (feed_q.size() > 0) begin
        bus.data_valid = 1'b1;
        bus.data_in    = feed_q[0];
      end else begin
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
      end
      #4;
      if (rst_n && bus.data_valid && bus.data_ready && feed_q.size() > 0) begin
        void'(feed_q.pop_front());
        if (!bus.clk_enable) off_strobe_xfers++;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic en;
    exp_t e;
    exp_t last;
    last = '0;
    forever begin
      @(posedge clk);
      en = bus.clk_enable;
      #1;
      if (rst_n) begin
        if (bus.data_ready) dr_seen = 1'b1;
        if (bus.bit_vld) begin
          if (en) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL extra_bit: got bit %0b with no bit expected at %0t",
                       bus.bit_out, $time);
            end else begin
              e    = exp_q.pop_front();
              last = e;
              check("bit_out", 32'(bus.bit_out), 32'(e.b));
              check("trn_flag", 32'(bus.trn_flag), 32'(e.f));
              bits_seen++;
            end
          end else begin
            check("bit_hold", 32'(bus.bit_out), 32'(last.b));
          end
        end
        if (bus.pkt_done) begin
          done_cnt++;
          check("done_on_strobe", 32'(en), 32'd1);
          check("bits_left_at_done", 32'(exp_q.size()), 32'd0);
          check("vld_at_done", 32'(bus.bit_vld), 32'd0);
          check("bit_out_at_done", 32'(bus.bit_out), 32'd0);
        end
      end
    end
  end

  task automatic push_expected(input int n, input logic [7:0] b0, input logic [7:0] b1,
                               input bit give);
    logic [7:0] l;
    logic [7:0] v;
    l = n[7:0];
    for (int i = 0; i < 16; i++) exp_q.push_back('{b: TrnPattern[15-i], f: (i < 12)});
    for (int i = 7; i >= 0; i--) exp_q.push_back('{b: l[i], f: 1'b0});
    for (int k = 0; k < n; k++) begin
      v = give ? ((k == 0) ? b0 : b1) : 8'h00;
      for (int i = 7; i >= 0; i--) exp_q.push_back('{b: v[i], f: 1'b0});
    end
    if (give) begin
      for (int k = 0; k < n; k++) feed_q.push_back((k == 0) ? b0 : b1);
    end
  endtask

  task automatic pulse_start(input logic [7:0] l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = 8'hEE;
  endtask

  task automatic send(input string tag, input int n, input logic [7:0] b0,
                      input logic [7:0] b1, input bit give, input bit exp_uf,
                      input bit extra_start);
    int d0;
    int bits0;
    int cyc;
    d0    = done_cnt;
    bits0 = bits_seen;
    dr_seen = 1'b0;
    push_expected(n, b0, b1, give);
    pulse_start(n[7:0]);
    check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    if (extra_start) begin
      repeat (20) @(negedge clk);
      pulse_start(8'd5);
    end
    cyc = 0;
    while (!bus.pkt_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(bus.pkt_done), 32'd1);
    check({tag, "_underflow"}, 32'(bus.underflow), 32'(exp_uf));
    // Start during the pkt_done cycle must be dropped.
    bus.start = 1'b1;
    bus.len   = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_busy_after_done"}, 32'(bus.busy), 32'd0);
    repeat (10) @(negedge clk);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_bit_count"}, 32'(bits_seen - bits0), 32'(16 + 8 + 8 * n));
    check({tag, "_idle_vld"}, 32'(bus.bit_vld), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_ready_seen"}, 32'(dr_seen), 32'(n != 0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bit_out"}, 32'(bus.bit_out), 32'd0);
    check({tag, "_bit_vld"}, 32'(bus.bit_vld), 32'd0);
    check({tag, "_trn_flag"}, 32'(bus.trn_flag), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_pkt_done"}, 32'(bus.pkt_done), 32'd0);
    check({tag, "_data_ready"}, 32'(bus.data_ready), 32'd0);
    check({tag, "_underflow"}, 32'(bus.underflow), 32'd0);
  endtask

  initial begin
    int d0;
    n_checks         = 0;
    n_errors         = 0;
    done_cnt         = 0;
    bits_seen        = 0;
    off_strobe_xfers = 0;
    en_period        = 1;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.len          = 8'h00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // len=1, 0xA5, strobe every clk.
    send("len1_a5", 1, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0);

    // Same packet with strobe every 4th clk.
    en_period = 4;
    off_strobe_xfers = 0;
    send("len1_a5_div4", 1, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0);
    check("xfer_between_strobes", 32'(off_strobe_xfers > 0), 32'd1);

    // len=2 with no data offered: two zero bytes and sticky underflow.
    en_period = 1;
    send("len2_starved", 2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // len=0: header only, no payload request; underflow cleared by the new start.
    send("len0", 0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Second start mid-packet is ignored.
    send("len2_dup_start", 2, 8'h3C, 8'hC3, 1'b1, 1'b0, 1'b1);

    // Reset mid-packet after underflow has been raised.
    d0 = done_cnt;
    push_expected(2, 8'h00, 8'h00, 1'b0);
    pulse_start(8'd2);
    repeat (32) @(negedge clk);
    check("pre_reset_underflow", 32'(bus.underflow), 32'd1);
    check("pre_reset_vld", 32'(bus.bit_vld), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    feed_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    check("midreset_idle_busy", 32'(bus.busy), 32'd0);

    // Fresh packet after reset, strobe every 2nd clk.
    en_period = 2;
    send("post_reset_5a", 1, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: time limit reached, got %0d done pulses", done_cnt);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
